// File: rtl/fact_scheduler_pkg.sv
// Shared constants and unit-state type for the factorial job scheduler.
package fact_sched_pkg;
    localparam int NUM_UNITS  = 4;
    localparam int UNIT_IDX_W = $clog2(NUM_UNITS);
    localparam int N_WIDTH    = 4;
    localparam int RES_WIDTH  = 32;

    typedef enum logic [1:0] {
        U_IDLE = 2'd0,
        U_BUSY = 2'd1,
        U_DONE = 2'd2
    } unit_state_e;
endpackage

// File: rtl/fact_scheduler_if.sv
// Request/response, factorial-unit handshake and status bundle for fact_scheduler.
interface fact_scheduler_if;
    import fact_sched_pkg::*;

    logic                           req_valid;
    logic                           req_ready;
    logic [N_WIDTH-1:0]             req_n;
    logic [NUM_UNITS-1:0]           fu_go;
    logic [N_WIDTH-1:0]             fu_n;
    logic [NUM_UNITS-1:0]           fu_done;
    logic [NUM_UNITS*RES_WIDTH-1:0] fu_result;
    logic [NUM_UNITS-1:0]           fu_err;
    logic                           rsp_valid;
    logic                           rsp_ready;
    logic [UNIT_IDX_W-1:0]          rsp_unit;
    logic [RES_WIDTH-1:0]           rsp_result;
    logic                           rsp_err;
    logic [NUM_UNITS-1:0]           busy_mask;
    logic                           protocol_err;

    // The scheduler itself
    modport slave (
        input  req_valid, req_n, fu_done, fu_result, fu_err, rsp_ready,
        output req_ready, fu_go, fu_n, rsp_valid, rsp_unit, rsp_result, rsp_err,
               busy_mask, protocol_err
    );

    // Requester, consumer and factorial units
    modport master (
        output req_valid, req_n, fu_done, fu_result, fu_err, rsp_ready,
        input  req_ready, fu_go, fu_n, rsp_valid, rsp_unit, rsp_result, rsp_err,
               busy_mask, protocol_err
    );
endinterface

// File: rtl/fact_scheduler_rr_pick.sv
// Round-robin picker: first set bit of i_req at or after i_ptr, wrapping.
module rr_pick
    import fact_sched_pkg::*;
#(
    parameter int N = NUM_UNITS,
    parameter int W = UNIT_IDX_W
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [N-1:0] o_gnt,
    output logic [W-1:0] o_idx,
    output logic         o_found
);
    logic [W-1:0] w_cand;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_found = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < N; k++) begin
            // N is a power of two, so the W-bit add wraps modulo N
            w_cand = i_ptr + W'(k);
            if (!o_found && i_req[w_cand]) begin
                o_found       = 1'b1;
                o_idx         = w_cand;
                o_gnt[w_cand] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fact_scheduler.sv
// Shares NUM_UNITS factorial units among one request stream; round-robin
// dispatch to idle units and round-robin collection of finished results.
module fact_scheduler
    import fact_sched_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    fact_scheduler_if.slave bus
);
    unit_state_e           r_state     [NUM_UNITS];
    unit_state_e           w_state_nxt [NUM_UNITS];
    logic [RES_WIDTH-1:0]  r_hold_res  [NUM_UNITS];
    logic [NUM_UNITS-1:0]  r_hold_err;
    logic [NUM_UNITS-1:0]  w_idle_mask, w_done_mask, w_disp_gnt, w_col_gnt;
    logic [UNIT_IDX_W-1:0] w_disp_idx, w_col_idx, r_disp_ptr, r_col_ptr;
    logic                  w_disp_found, w_col_found;
    logic                  w_accept, w_rsp_free, w_load, w_perr_set;
    logic [NUM_UNITS-1:0]  r_fu_go;
    logic [N_WIDTH-1:0]    r_fu_n;
    logic                  r_rsp_valid, r_rsp_err, r_perr;
    logic [UNIT_IDX_W-1:0] r_rsp_unit;
    logic [RES_WIDTH-1:0]  r_rsp_result;

    always_comb begin
        w_idle_mask = '0;
        w_done_mask = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            w_idle_mask[i] = (r_state[i] == U_IDLE);
            w_done_mask[i] = (r_state[i] == U_DONE);
        end
    end

    rr_pick u_disp_pick (
        .i_req   (w_idle_mask),
        .i_ptr   (r_disp_ptr),
        .o_gnt   (w_disp_gnt),
        .o_idx   (w_disp_idx),
        .o_found (w_disp_found)
    );

    rr_pick u_col_pick (
        .i_req   (w_done_mask),
        .i_ptr   (r_col_ptr),
        .o_gnt   (w_col_gnt),
        .o_idx   (w_col_idx),
        .o_found (w_col_found)
    );

    assign w_accept   = bus.req_valid && bus.req_ready;
    assign w_rsp_free = !r_rsp_valid || bus.rsp_ready;
    assign w_load     = w_rsp_free && w_col_found;

    // Per-unit state machine; a done pulse outside BUSY only flags an error
    always_comb begin
        w_perr_set = 1'b0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            w_state_nxt[i] = r_state[i];
            case (r_state[i])
                U_IDLE: begin
                    if (w_accept && w_disp_gnt[i]) w_state_nxt[i] = U_BUSY;
                    if (bus.fu_done[i])            w_perr_set     = 1'b1;
                end
                U_BUSY: begin
                    if (bus.fu_done[i]) w_state_nxt[i] = U_DONE;
                end
                U_DONE: begin
                    if (w_load && w_col_gnt[i]) w_state_nxt[i] = U_IDLE;
                    if (bus.fu_done[i])         w_perr_set     = 1'b1;
                end
                default: w_state_nxt[i] = U_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                r_state[i]    <= U_IDLE;
                r_hold_res[i] <= '0;
            end
            r_hold_err <= '0;
        end else begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                r_state[i] <= w_state_nxt[i];
                if (r_state[i] == U_BUSY && bus.fu_done[i]) begin
                    r_hold_res[i] <= bus.fu_result[i*RES_WIDTH +: RES_WIDTH];
                    r_hold_err[i] <= bus.fu_err[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_disp_ptr <= '0;
            r_fu_go    <= '0;
            r_fu_n     <= '0;
        end else begin
            r_fu_go <= w_accept ? w_disp_gnt : '0;
            if (w_accept) begin
                r_fu_n     <= bus.req_n;
                r_disp_ptr <= w_disp_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col_ptr    <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_unit   <= '0;
            r_rsp_result <= '0;
            r_rsp_err    <= 1'b0;
            r_perr       <= 1'b0;
        end else begin
            r_perr <= r_perr | w_perr_set;
            if (w_load) begin
                r_rsp_valid  <= 1'b1;
                r_rsp_unit   <= w_col_idx;
                r_rsp_result <= r_hold_res[w_col_idx];
                r_rsp_err    <= r_hold_err[w_col_idx];
                r_col_ptr    <= w_col_idx + 1'b1;
            end else if (w_rsp_free) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign bus.req_ready    = w_disp_found && !rst;
    assign bus.fu_go        = r_fu_go;
    assign bus.fu_n         = r_fu_n;
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_unit     = r_rsp_unit;
    assign bus.rsp_result   = r_rsp_result;
    assign bus.rsp_err      = r_rsp_err;
    assign bus.busy_mask    = ~w_idle_mask;
    assign bus.protocol_err = r_perr;
endmodule

// File: tb/tb_fact_scheduler.sv
// Directed scenarios plus a randomized run against a job-level model of the scheduler.
module tb_fact_scheduler;
    import fact_sched_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fact_scheduler_if bus ();
    fact_scheduler dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_errors = 0;

    // model state: 0 idle, 1 running, 2 finished and not yet returned
    int          st  [NUM_UNITS];
    int          jn  [NUM_UNITS];
    int          lat [NUM_UNITS];
    int          mptr, disp_cnt, rsp_cnt;
    bit          prev_acc, prev_valid, prev_ready;
    logic [3:0]  exp_go, exp_n;
    logic [63:0] prev_rsp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] fact64(input int n);
        logic [63:0] f = 64'd1;
        for (int i = 2; i <= n; i++) f = f * 64'(i);
        return f;
    endfunction

    task automatic set_res(input int u, input logic [31:0] v);
        bus.fu_result[u*RES_WIDTH +: RES_WIDTH] = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.fu_done = '0; bus.fu_err = '0; bus.rsp_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_go"},     64'(bus.fu_go), 0);
        chk({tag, "_n"},      64'(bus.fu_n), 0);
        chk({tag, "_rv"},     64'(bus.rsp_valid), 0);
        chk({tag, "_ru"},     64'(bus.rsp_unit), 0);
        chk({tag, "_rr"},     64'(bus.rsp_result), 0);
        chk({tag, "_re"},     64'(bus.rsp_err), 0);
        chk({tag, "_busy"},   64'(bus.busy_mask), 0);
        chk({tag, "_perr"},   64'(bus.protocol_err), 0);
        chk({tag, "_ready"},  64'(bus.req_ready), 0);
    endtask

    task automatic issue4();
        for (int i = 1; i <= 4; i++) begin
            bus.req_valid = 1'b1; bus.req_n = 4'(i);
            tick();
            chk("issue_go", 64'(bus.fu_go), 64'(1) << (i - 1));
            chk("issue_n",  64'(bus.fu_n), 64'(i));
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic rnd_cycle(input bit active);
        int u;
        bit any_idle;
        logic [63:0] f;
        chk("rnd_go", 64'(bus.fu_go), prev_acc ? 64'(exp_go) : 64'd0);
        if (prev_acc) begin
            chk("rnd_fu_n", 64'(bus.fu_n), 64'(exp_n));
            for (int k = 0; k < NUM_UNITS; k++) if (exp_go[k]) u = k;
            st[u] = 1; jn[u] = int'(exp_n); lat[u] = $urandom_range(1, 6);
            disp_cnt++;
        end
        if (bus.rsp_valid && (!prev_valid || prev_ready)) begin
            u = int'(bus.rsp_unit);
            f = fact64(jn[u]);
            chk("rnd_rsp_owner", 64'(st[u]), 2);
            chk("rnd_rsp_result", 64'(bus.rsp_result), 64'(f[31:0]));
            chk("rnd_rsp_err", 64'(bus.rsp_err), 64'(f > 64'hFFFF_FFFF));
            st[u] = 0;
            rsp_cnt++;
        end else if (bus.rsp_valid && prev_valid) begin
            chk("rnd_rsp_hold", {29'd0, bus.rsp_err, bus.rsp_unit, bus.rsp_result}, prev_rsp);
        end
        any_idle = 1'b0;
        for (int k = 0; k < NUM_UNITS; k++) if (st[k] == 0) any_idle = 1'b1;
        chk("rnd_ready", 64'(bus.req_ready), 64'(any_idle));
        prev_valid = bus.rsp_valid;
        prev_rsp   = {29'd0, bus.rsp_err, bus.rsp_unit, bus.rsp_result};

        bus.fu_done = '0; bus.fu_err = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (st[k] == 1) begin
                lat[k]--;
                if (lat[k] == 0) begin
                    f = fact64(jn[k]);
                    bus.fu_done[k] = 1'b1;
                    bus.fu_err[k]  = (f > 64'hFFFF_FFFF);
                    set_res(k, f[31:0]);
                    st[k] = 2;
                end
            end
        end
        bus.req_valid = active && ($urandom_range(0, 3) != 0);
        bus.req_n     = 4'($urandom_range(0, 15));
        bus.rsp_ready = !active || ($urandom_range(0, 2) != 0);
        prev_ready    = bus.rsp_ready;
        prev_acc      = bus.req_valid && bus.req_ready;
        if (prev_acc) begin
            u = -1;
            for (int k = 0; k < NUM_UNITS; k++)
                if (u < 0 && st[(mptr + k) % NUM_UNITS] == 0) u = (mptr + k) % NUM_UNITS;
            exp_go = 4'(1 << u);
            exp_n  = bus.req_n;
            mptr   = (u + 1) % NUM_UNITS;
        end
    endtask

    initial begin
        bit all_idle;
        bus.req_valid = 1'b0; bus.req_n = '0; bus.fu_done = '0;
        bus.fu_result = '0; bus.fu_err = '0; bus.rsp_ready = 1'b0;

        // reset values
        tick(); tick();
        check_reset_outputs("rst");
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 64'(bus.req_ready), 1);

        // single job
        bus.req_valid = 1'b1; bus.req_n = 4'd5;
        tick();
        bus.req_valid = 1'b0;
        chk("single_go", 64'(bus.fu_go), 64'h1);
        chk("single_n", 64'(bus.fu_n), 5);
        chk("single_busy", 64'(bus.busy_mask), 64'h1);
        tick();
        chk("single_go_pulse", 64'(bus.fu_go), 0);
        tick(); tick();
        bus.fu_done = 4'b0001; set_res(0, 32'd120);
        tick();
        bus.fu_done = '0;
        chk("single_rv_early", 64'(bus.rsp_valid), 0);
        tick();
        chk("single_rv", 64'(bus.rsp_valid), 1);
        chk("single_unit", 64'(bus.rsp_unit), 0);
        chk("single_result", 64'(bus.rsp_result), 120);
        chk("single_err", 64'(bus.rsp_err), 0);
        bus.rsp_ready = 1'b1;
        tick();
        chk("single_drained", 64'(bus.rsp_valid), 0);
        chk("single_idle", 64'(bus.busy_mask), 0);

        // dispatch exhaustion
        do_reset();
        issue4();
        bus.req_valid = 1'b1; bus.req_n = 4'd5;
        chk("exh_ready", 64'(bus.req_ready), 0);
        chk("exh_busy", 64'(bus.busy_mask), 64'hF);
        tick();
        chk("exh_no_go", 64'(bus.fu_go), 0);
        bus.fu_done = 4'b0100; set_res(2, 32'd6);
        tick();
        bus.fu_done = '0;
        chk("exh_ready_d1", 64'(bus.req_ready), 0);
        tick();
        chk("exh_ready_d2", 64'(bus.req_ready), 1);
        tick();
        bus.req_valid = 1'b0;
        chk("exh_redispatch_go", 64'(bus.fu_go), 64'h4);
        chk("exh_redispatch_n", 64'(bus.fu_n), 5);

        // simultaneous completion
        do_reset();
        issue4();
        bus.rsp_ready = 1'b1;
        bus.fu_done = 4'b1111;
        set_res(0, 32'd1); set_res(1, 32'd2); set_res(2, 32'd6); set_res(3, 32'd24);
        tick();
        bus.fu_done = '0;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("sim_rv", 64'(bus.rsp_valid), 1);
            chk("sim_unit", 64'(bus.rsp_unit), 64'(k));
            chk("sim_result", 64'(bus.rsp_result), 64'(fact64(k + 1)));
            tick();
        end
        chk("sim_drained", 64'(bus.rsp_valid), 0);

        // backpressure
        do_reset();
        issue4();
        bus.fu_done = 4'b1010; set_res(1, 32'd11); set_res(3, 32'd33);
        tick();
        bus.fu_done = '0;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("bp_rv", 64'(bus.rsp_valid), 1);
            chk("bp_unit", 64'(bus.rsp_unit), 1);
            chk("bp_result", 64'(bus.rsp_result), 11);
            chk("bp_busy3", 64'(bus.busy_mask[3]), 1);
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        chk("bp_next_unit", 64'(bus.rsp_unit), 3);
        chk("bp_next_result", 64'(bus.rsp_result), 33);
        tick();
        chk("bp_drained", 64'(bus.rsp_valid), 0);

        // error paths
        do_reset();
        bus.req_valid = 1'b1; bus.req_n = 4'd2;
        tick();
        bus.req_n = 4'd13;
        tick();
        bus.req_valid = 1'b0;
        chk("err_go", 64'(bus.fu_go), 64'h2);
        bus.fu_done = 4'b0010; bus.fu_err = 4'b0010; set_res(1, 32'h7328_CC00);
        tick();
        bus.fu_done = '0; bus.fu_err = '0;
        tick();
        chk("err_rv", 64'(bus.rsp_valid), 1);
        chk("err_unit", 64'(bus.rsp_unit), 1);
        chk("err_flag", 64'(bus.rsp_err), 1);
        bus.rsp_ready = 1'b1;
        tick();
        chk("err_perr_clear", 64'(bus.protocol_err), 0);
        bus.fu_done = 4'b1000;
        tick();
        bus.fu_done = '0;
        chk("perr_set", 64'(bus.protocol_err), 1);
        tick(); tick(); tick();
        chk("perr_sticky", 64'(bus.protocol_err), 1);
        chk("perr_no_rsp", 64'(bus.rsp_valid), 0);
        chk("perr_busy", 64'(bus.busy_mask), 64'h1);

        // reset mid-operation
        bus.rsp_ready = 1'b0;
        bus.fu_done = 4'b0001; set_res(0, 32'd2);
        bus.req_valid = 1'b1; bus.req_n = 4'd7;
        tick();
        bus.fu_done = '0;
        bus.req_n = 4'd8;
        tick();
        bus.req_valid = 1'b0;
        chk("mid_rv", 64'(bus.rsp_valid), 1);
        chk("mid_busy", 64'(bus.busy_mask), 64'hC);
        rst = 1'b1;
        tick();
        check_reset_outputs("mid_rst");
        rst = 1'b0;
        #1;
        chk("mid_ready", 64'(bus.req_ready), 1);
        bus.req_valid = 1'b1; bus.req_n = 4'd9;
        tick();
        bus.req_valid = 1'b0;
        chk("mid_go", 64'(bus.fu_go), 64'h1);
        chk("mid_n", 64'(bus.fu_n), 9);

        // randomized traffic against the job model
        do_reset();
        for (int k = 0; k < NUM_UNITS; k++) begin st[k] = 0; jn[k] = 0; lat[k] = 0; end
        mptr = 0; disp_cnt = 0; rsp_cnt = 0;
        prev_acc = 1'b0; prev_valid = 1'b0; prev_ready = 1'b0; prev_rsp = '0;
        for (int c = 0; c < 3000; c++) begin
            rnd_cycle(1'b1);
            tick();
        end
        all_idle = 1'b0;
        for (int c = 0; c < 200 && !all_idle; c++) begin
            rnd_cycle(1'b0);
            tick();
            all_idle = !bus.rsp_valid && !prev_acc;
            for (int k = 0; k < NUM_UNITS; k++) if (st[k] != 0) all_idle = 1'b0;
        end
        chk("drain_idle", 64'(all_idle), 1);
        chk("drain_busy", 64'(bus.busy_mask), 0);
        chk("rsp_count", 64'(rsp_cnt), 64'(disp_cnt));
        chk("rnd_perr", 64'(bus.protocol_err), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
